// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, symbol width, rotor notches, rotor stage states.
// Pure declarations; no timing or flow control of its own.
package enigma_pkg;

  localparam int N_ALPHA = 26;
  localparam int SYM_W   = 5;

  // Stepping off these positions carries into the next rotor (Q, E, V, J, Z).
  localparam int NOTCH_I   = 16;
  localparam int NOTCH_II  = 4;
  localparam int NOTCH_III = 21;
  localparam int NOTCH_IV  = 9;
  localparam int NOTCH_V   = 25;

  typedef enum logic {
    ST_CFG = 1'b0,
    ST_RUN = 1'b1
  } rotor_state_t;

endpackage

// File: rtl/rotor_modadd.sv
// Combinational (a +/- b) mod N for operands already in 0..N-1.
// Zero latency; no flow control.
module rotor_modadd #(
  parameter int N = 26,
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  localparam logic [W:0] N_X = (W+1)'(N);

  logic [W:0] raw;

  // One extra bit holds the carry or borrow; a single correction by N folds it back.
  always_comb begin
    raw = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    y   = raw[W-1:0];
    if (sub) begin
      if (raw[W]) y = raw[W-1:0] + N_X[W-1:0];
    end else if (raw >= N_X) begin
      y = raw[W-1:0] - N_X[W-1:0];
    end
  end

endmodule

// File: rtl/rotor_stage.sv
// Enigma rotor stage with loadable wiring, ring, position and notch carry; one-cycle latency.
// Valid/ready both sides: output held while out_ready low; in_ready low in CFG or while stalled.
module rotor_stage
  import enigma_pkg::*;
#(
  parameter int N     = N_ALPHA,
  parameter int W     = SYM_W,
  parameter int NOTCH = NOTCH_I
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         ring_we,
  input  logic [W-1:0] ring_val,
  input  logic         pos_we,
  input  logic [W-1:0] pos_val,
  input  logic         step,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic [W-1:0] pos,
  output logic         carry_out
);

  localparam logic [W:0]   N_X     = (W+1)'(N);
  localparam logic [W-1:0] LAST    = W'(N - 1);
  localparam logic [W-1:0] NOTCH_P = W'(NOTCH);
  localparam logic [W-1:0] ONE     = W'(1);

  rotor_state_t state, state_nxt;

  logic [W-1:0] fwd [N];
  logic [W-1:0] rev [N];
  logic [W-1:0] ring;

  logic [W-1:0] off, idx, lut, sub_res, in_sym;
  logic         in_ok, accept, any_we, step_en;

  assign any_we  = cfg_we | ring_we | pos_we;
  assign in_ok   = ({1'b0, in_data} < N_X);
  // Out-of-range symbols are masked so the table index always stays in bounds.
  assign in_sym  = in_ok ? in_data : '0;
  assign lut     = in_dir ? rev[idx] : fwd[idx];
  assign accept  = in_valid & in_ready;
  assign step_en = (state == ST_RUN) & step & ~pos_we;

  rotor_modadd #(.N(N), .W(W)) u_off (.a(pos),    .b(ring), .sub(1'b1), .y(off));
  rotor_modadd #(.N(N), .W(W)) u_idx (.a(in_sym), .b(off),  .sub(1'b0), .y(idx));
  rotor_modadd #(.N(N), .W(W)) u_out (.a(lut),    .b(off),  .sub(1'b1), .y(sub_res));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_CFG: if (!any_we && !out_valid) state_nxt = ST_RUN;
      ST_RUN: begin
        in_ready = !out_valid || out_ready;
        if (any_we) state_nxt = ST_CFG;
      end
      default: state_nxt = ST_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_CFG;
      pos       <= '0;
      ring      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      carry_out <= 1'b0;
      for (int i = 0; i < N; i++) begin
        fwd[i] <= W'(i);
        rev[i] <= W'(i);
      end
    end else begin
      state     <= state_nxt;
      carry_out <= step_en && (pos == NOTCH_P);

      if (pos_we) begin
        if ({1'b0, pos_val} < N_X) pos <= pos_val;
      end else if (step_en) begin
        pos <= (pos == LAST) ? '0 : pos + ONE;
      end

      if (ring_we && ({1'b0, ring_val} < N_X)) ring <= ring_val;

      if (cfg_we && ({1'b0, cfg_addr} < N_X) && ({1'b0, cfg_data} < N_X)) begin
        fwd[cfg_addr] <= cfg_data;
        rev[cfg_data] <= cfg_addr;
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_ok ? sub_res : '0;
        out_err   <= !in_ok;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Bench for rotor_stage: directed scenarios plus a randomized stream scored against
// a plain-arithmetic Enigma rotor model.
module tb_rotor_stage;

  localparam int N = 26;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_we = 1'b0;
  logic [W-1:0] cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic         ring_we = 1'b0;
  logic [W-1:0] ring_val = '0;
  logic         pos_we = 1'b0;
  logic [W-1:0] pos_val = '0;
  logic         step = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_dir = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_err;
  logic [W-1:0] pos;
  logic         carry_out;

  int compared = 0;
  int mismatched = 0;

  int m_fwd [N];
  int m_rev [N];
  int m_pos;
  int m_ring;

  string rotor_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

  rotor_stage #(.N(N), .W(W), .NOTCH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .ring_we(ring_we), .ring_val(ring_val),
    .pos_we(pos_we), .pos_val(pos_val), .step(step),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .pos(pos), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  function automatic int model(int sym, int dir);
    int off, idx, v;
    if (sym >= N) return 0;
    off = ((m_pos - m_ring) % N + N) % N;
    idx = (sym + off) % N;
    v   = (dir != 0) ? m_rev[idx] : m_fwd[idx];
    return (v - off + N) % N;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_fwd[i] = i;
      m_rev[i] = i;
    end
    m_pos  = 0;
    m_ring = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    cfg_we = 1'b0; ring_we = 1'b0; pos_we = 1'b0; step = 1'b0; out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic send(input int sym, input int dir, output int d, output int e, output int v);
    int n;
    in_data = W'(sym); in_dir = dir[0]; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: in_ready=%0d required 1", in_ready);
      in_valid = 1'b0; d = -1; e = -1; v = -1;
      return;
    end
    tick();
    in_valid = 1'b0;
    v = int'(out_valid); d = int'(out_data); e = int'(out_err);
  endtask

  task automatic load_rotor(input string w);
    int c;
    for (int i = 0; i < N; i++) begin
      c = int'(w[i]) - 65;
      cfg_we = 1'b1; cfg_addr = W'(i); cfg_data = W'(c);
      tick();
      m_fwd[i] = c;
      m_rev[c] = i;
    end
    cfg_we = 1'b0;
  endtask

  task automatic set_pr(input int p, input int r);
    pos_we = 1'b1; pos_val = W'(p); ring_we = 1'b1; ring_val = W'(r);
    tick();
    pos_we = 1'b0; ring_we = 1'b0;
    m_pos = p; m_ring = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %0d expected 0", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %0d expected 0", out_valid); end
    compared++; if (int'(out_data) !== 0) begin mismatched++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    compared++; if (out_err !== 1'b0) begin mismatched++; $display("FAIL rst_out_err: got %0d expected 0", out_err); end
    compared++; if (int'(pos) !== 0) begin mismatched++; $display("FAIL rst_pos: got %0d expected 0", pos); end
    compared++; if (carry_out !== 1'b0) begin mismatched++; $display("FAIL rst_carry: got %0d expected 0", carry_out); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_identity();
    int d, e, v;
    go_run();
    send(7, 0, d, e, v);
    compared++; if (v !== 1) begin mismatched++; $display("FAIL id_valid: got %0d expected 1", v); end
    compared++; if (d !== 7) begin mismatched++; $display("FAIL id_data: got %0d expected 7", d); end
    compared++; if (e !== 0) begin mismatched++; $display("FAIL id_err: got %0d expected 0", e); end
  endtask

  task automatic test_rotor_i();
    int d, e, v;
    load_rotor(rotor_i);
    set_pr(0, 0);
    go_run();
    send(0, 0, d, e, v);
    compared++; if (d !== 4) begin mismatched++; $display("FAIL r1_p0_fwd: got %0d expected 4", d); end
    send(4, 1, d, e, v);
    compared++; if (d !== 0) begin mismatched++; $display("FAIL r1_p0_rev: got %0d expected 0", d); end
    set_pr(1, 0);
    go_run();
    send(0, 0, d, e, v);
    compared++; if (d !== 9) begin mismatched++; $display("FAIL r1_p1_fwd: got %0d expected 9", d); end
    send(9, 1, d, e, v);
    compared++; if (d !== 0) begin mismatched++; $display("FAIL r1_p1_rev: got %0d expected 0", d); end
    set_pr(1, 1);
    go_run();
    send(0, 0, d, e, v);
    compared++; if (d !== 4) begin mismatched++; $display("FAIL r1_ring1_fwd: got %0d expected 4", d); end
  endtask

  task automatic test_stepping();
    pos_we = 1'b1; pos_val = W'(16);
    tick();
    pos_we = 1'b0; step = 1'b1;
    tick();
    compared++; if (int'(pos) !== 16) begin mismatched++; $display("FAIL step_in_cfg: pos=%0d expected 16", pos); end
    tick();
    step = 1'b0;
    compared++; if (int'(pos) !== 17) begin mismatched++; $display("FAIL step_notch_pos: got %0d expected 17", pos); end
    compared++; if (carry_out !== 1'b1) begin mismatched++; $display("FAIL step_notch_carry: got %0d expected 1", carry_out); end
    tick();
    compared++; if (carry_out !== 1'b0) begin mismatched++; $display("FAIL step_carry_pulse: got %0d expected 0", carry_out); end
    pos_we = 1'b1; pos_val = W'(25);
    tick();
    pos_we = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    compared++; if (int'(pos) !== 0) begin mismatched++; $display("FAIL step_wrap_pos: got %0d expected 0", pos); end
    compared++; if (carry_out !== 1'b0) begin mismatched++; $display("FAIL step_wrap_carry: got %0d expected 0", carry_out); end
    tick();
    compared++; if (carry_out !== 1'b0) begin mismatched++; $display("FAIL step_wrap_carry2: got %0d expected 0", carry_out); end
    m_pos = 0;
  endtask

  task automatic test_stream();
    int syms [8];
    int dirs [8];
    int expq [$];
    int sent, got, start_pos, prev;
    bit hold, stepped;
    for (int i = 0; i < 8; i++) begin
      syms[i] = $urandom_range(0, N - 1);
      dirs[i] = $urandom_range(0, 1);
    end
    set_pr($urandom_range(0, N - 1), $urandom_range(0, N - 1));
    go_run();
    start_pos = m_pos;
    sent = 0; got = 0; hold = 0; stepped = 0; prev = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = W'(syms[sent]);
        in_dir  = dirs[sent][0];
      end
      step = 1'b0;
      #1;
      if (sent == 4 && !stepped && in_ready) step = 1'b1;
      compared++;
      if (in_ready !== (!out_valid || out_ready)) begin
        mismatched++; $display("FAIL stream_ready cyc %0d: got %0d expected %0d", cyc, in_ready, !out_valid || out_ready);
      end
      if (out_valid) begin
        if (hold) begin
          compared++;
          if (int'(out_data) !== prev) begin mismatched++; $display("FAIL stream_hold: got %0d expected %0d", out_data, prev); end
        end
        if (out_ready) begin
          compared++;
          if (expq.size() == 0) begin
            mismatched++; $display("FAIL stream_dup: got %0d expected no output", out_data);
          end else begin
            if (int'(out_data) !== expq[0]) begin mismatched++; $display("FAIL stream_data %0d: got %0d expected %0d", got, out_data, expq[0]); end
            void'(expq.pop_front());
          end
          got++;
        end
      end
      hold = out_valid && !out_ready;
      prev = int'(out_data);
      if (in_valid && in_ready) begin
        expq.push_back(model(syms[sent], dirs[sent]));
        sent++;
        if (step) begin
          m_pos = (m_pos + 1) % N;
          stepped = 1;
        end
      end
      tick();
    end
    in_valid = 1'b0; step = 1'b0; out_ready = 1'b1;
    compared++; if (got !== 8) begin mismatched++; $display("FAIL stream_count: got %0d expected 8", got); end
    compared++; if (int'(pos) !== (start_pos + 1) % N) begin mismatched++; $display("FAIL stream_pos: got %0d expected %0d", pos, (start_pos + 1) % N); end
  endtask

  task automatic test_err();
    int d, e, v, x;
    go_run();
    send(30, 0, d, e, v);
    compared++; if (d !== 0) begin mismatched++; $display("FAIL err_data: got %0d expected 0", d); end
    compared++; if (e !== 1) begin mismatched++; $display("FAIL err_flag: got %0d expected 1", e); end
    x = model(5, 0);
    send(5, 0, d, e, v);
    compared++; if (e !== 0) begin mismatched++; $display("FAIL err_clear: got %0d expected 0", e); end
    compared++; if (d !== x) begin mismatched++; $display("FAIL err_next_data: got %0d expected %0d", d, x); end
  endtask

  task automatic test_cfg_midstream();
    int s, x;
    go_run();
    s = $urandom_range(0, N - 1);
    x = model(s, 0);
    in_valid = 1'b1; in_data = W'(s); in_dir = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = W'(m_fwd[0]);
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL cfg_pre_ready: got %0d expected 1", in_ready); end
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL cfg_ready_drop: got %0d expected 0", in_ready); end
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL cfg_pending: got %0d expected 1", out_valid); end
    tick();
    compared++; if (int'(out_data) !== x || out_valid !== 1'b1) begin mismatched++; $display("FAIL cfg_pending_data: got %0d/%0d expected %0d/1", out_data, out_valid, x); end
    out_ready = 1'b1;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL cfg_drain: got %0d expected 0", out_valid); end
    tick();
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL cfg_back_run: got %0d expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int d, e, v;
    go_run();
    in_valid = 1'b1; in_data = W'(3); in_dir = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_valid: got %0d expected 0", out_valid); end
    rst_n = 1'b1;
    model_reset();
    go_run();
    send(0, 0, d, e, v);
    compared++; if (d !== 0) begin mismatched++; $display("FAIL rstmid_identity: got %0d expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotor_i();
    test_stepping();
    test_stream();
    test_err();
    test_cfg_midstream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotor_stage.md
# rotor_stage

Clocked, parametrised Enigma rotor stage with run-time loadable wiring, ring setting, position stepping and notch carry. A single instance serves the forward path, the reverse path, or both, selected per character. It sits in the encryption and decryption datapaths between the plugboard and reflector stages, chained one instance per rotor. Valid/ready handshakes on both sides let it pipeline with neighbouring stages.

## Interface
Parameters:
- N, 26: alphabet size; symbols are 0..N-1.
- W, 5: symbol width; must satisfy 2^W ≥ N.
- NOTCH, 16: position at which stepping off it raises carry (16 = Q, rotor I).

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  wiring write strobe.
- cfg_addr  in  W  wiring input symbol.
- cfg_data  in  W  wiring output symbol.
- ring_we  in  1  ring-setting write strobe.
- ring_val  in  W  ring setting.
- pos_we  in  1  position load strobe.
- pos_val  in  W  position load value.
- step  in  1  advance the position by one.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  stage can accept a symbol.
- in_data  in  W  input symbol.
- in_dir  in  1  0 = forward (wiring), 1 = reverse (inverse wiring).
- out_valid  out  1  output symbol valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  substituted symbol.
- out_err  out  1  the input symbol was out of range.
- pos  out  W  current position.
- carry_out  out  1  one-cycle pulse to step the next rotor.

## Operation
- Two FSM states: CFG and RUN. Reset enters CFG.
- CFG → RUN when cfg_we, ring_we and pos_we are all low for one cycle and no output is pending. RUN → CFG on any asserted write strobe. While in CFG, in_ready = 0.
- A cfg_we write sets fwd[cfg_addr] = cfg_data and rev[cfg_data] = cfg_addr at the same edge. Writes with cfg_addr or cfg_data ≥ N are ignored. Keeping the wiring a permutation is the loader's responsibility.
- Reset sets both tables to identity, pos = 0 and ring = 0. ring_we and pos_we values ≥ N are ignored.
- Offset: off = (pos − ring) mod N.
- Forward: out = (fwd[(in + off) mod N] − off) mod N.
- Reverse: out = (rev[(in + off) mod N] − off) mod N.
- Modular arithmetic is done at W+1 bits with a single conditional add or subtract of N. The % operator is not used.
- If in_data ≥ N, out_data = 0 and out_err = 1; otherwise out_err = 0.
- step in RUN: pos ← pos+1, wrapping N−1 → 0. carry_out = 1 for exactly one cycle when pos steps from NOTCH. step in CFG is ignored.
- pos_we takes priority over step at the same edge and produces no carry.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_err 0, pos 0, carry_out 0.
- Latency: one cycle. A symbol accepted at edge k (in_valid & in_ready) appears with out_valid high after edge k.
- in_ready = (state == RUN) & (!out_valid | out_ready). This gives full throughput of one symbol per cycle under continuous out_ready.
- Output holds stable while out_valid & !out_ready.
- If step and an accept occur at the same edge, the symbol uses the pre-step pos. The next symbol sees the new pos.
- carry_out is registered and asserted the cycle after the stepping edge.
- Reset mid-operation drops any pending output: out_valid → 0 and the tables return to identity.

## Structure
- A shared package enigma_pkg holds N_ALPHA = 26, SYM_W = 5, the notch constants for rotors I–V, and the fsm state typedef.
- One sub-module, rotor_modadd: a combinational (a ± b) mod N over W bits. It is instantiated three times: in+off, lookup−off, and pos−ring.
- The tables are two N-entry register arrays, so that reset to identity is possible.

## Test plan
- Reset, then forward in_data 7 with pos 0 → out_data 7 (identity), out_err 0.
- Load rotor I wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ with pos 0, ring 0: forward 0 → 4, then reverse 4 → 0.
- Same wiring, pos 1: forward 0 → 9, reverse 9 → 0. With ring 1 and pos 1: forward 0 → 4.
- pos_we 16, then step → pos 17 and carry_out high for exactly one cycle. pos_we 25, then step → pos 0 with no carry.
- Stream 8 symbols with out_ready held low for 3 cycles mid-stream → no loss or duplication, output held stable, step coincident with an accept uses the old pos.
- in_data 30 → out_data 0, out_err 1. cfg_we asserted mid-stream → in_ready drops the next cycle and the pending output still drains.
